fp_mul_pipe: RTL
================

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 The module SHALL have parameter EXP_W, default 8, meaning exponent width.
REQ-002 The module SHALL have parameter MAN_W, default 23, meaning stored fraction width; operand width W = 1+EXP_W+MAN_W.
REQ-003 The module SHALL have parameter TAG_W, default 4, meaning width of the opaque tag carried alongside each operation.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The module SHALL have port in_valid, input, 1 bit: operands present.
REQ-007 The module SHALL have port in_ready, output, 1 bit: operation accepted when in_valid and in_ready are both high on a clk edge.
REQ-008 The module SHALL have ports a_in and b_in, input, W bits each: IEEE-754-format operands.
REQ-009 The module SHALL have port rm, input, 3 bits: rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE).
REQ-010 The module SHALL have port in_tag, input, TAG_W bits: tag captured with the operands.
REQ-011 The module SHALL have port out_valid, output, 1 bit: result present.
REQ-012 The module SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 The module SHALL have port result, output, W bits: rounded product.
REQ-014 The module SHALL have port out_tag, output, TAG_W bits: tag of the result.
REQ-015 The module SHALL have port flags, output, 5 bits: {NV, DZ, OF, UF, NX}; DZ is always 0.

Function
REQ-016 The pipeline SHALL have four register stages: unpack/classify, mantissa product, normalise, round/pack.
REQ-017 An accepted operation SHALL appear on out_valid exactly 4 cycles after acceptance when not stalled; full throughput SHALL be one operation per cycle.
REQ-018 Stall: when out_valid=1 and out_ready=0, all stages SHALL hold and in_ready SHALL be 0; otherwise in_ready SHALL be 1.
REQ-019 result, out_tag and flags SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 Results SHALL emerge in acceptance order, with none lost or duplicated across stalls; bubbles SHALL propagate as invalid stages.
REQ-021 The result sign SHALL be sign(a) XOR sign(b) for zero, infinite and finite results.
REQ-022 Any NaN operand, or infinity times zero, SHALL produce canonical qNaN (0x7FC00000 at defaults); NV SHALL be set for a signalling NaN operand or for infinity times zero.
REQ-023 Infinity times a finite non-zero value SHALL produce signed infinity with flags 0.
REQ-024 Rounding SHALL follow rm on the full 2*(MAN_W+1)-bit product using guard and sticky bits; NX SHALL be set when the result is inexact.
REQ-025 On overflow, OF and NX SHALL be set; the result SHALL be infinity for RNE and RMM, and the largest finite value for RTZ; RDN and RUP SHALL round toward their own direction.
REQ-026 The exponent path SHALL use EXP_W+2 signed bits so that no intermediate wraps.

Reset
REQ-027 While rst is high, all stage valid bits SHALL be cleared; out_valid, result, out_tag and flags SHALL be 0; and in_ready SHALL be 0.
REQ-028 Asserting rst mid-operation SHALL discard every in-flight operation; none SHALL emerge after release.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-030 With FP_MUL_SUBNORMAL_EN defined, subnormal inputs SHALL be used at full value, tiny results SHALL be denormalised before rounding, and UF SHALL be set only when the result is tiny and inexact.
REQ-031 Without FP_MUL_SUBNORMAL_EN, subnormal inputs SHALL be treated as signed zero, and tiny results SHALL flush to signed zero with UF and NX set.

Verification
REQ-032 Basic case: 0x3FC00000 * 0x40000000, rm=RNE -> result 0x40400000, flags 0, out_valid exactly 4 cycles after acceptance.
REQ-033 Stall case: three back-to-back ops (2*3, 4*0.5, 10*10) with tags 1, 2, 3, and out_ready low for 2 cycles at first output -> 0x40C00000/1, 0x40000000/2, 0x42C80000/3 in order; in_ready low during the stall.
REQ-034 Rounding case: 0x3F800001 squared -> RNE gives 0x3F800002 with NX; RUP gives 0x3F800003 with NX.
REQ-035 Special and overflow cases: 0x7F800000 * 0x00000000 -> 0x7FC00000 with NV; 0x7F000000 * 0x40000000 -> RTZ gives 0x7F7FFFFF and RNE gives 0x7F800000, both with OF and NX.
REQ-036 Subnormal case: 0x00800000 * 0x3F000000 -> with macro, 0x00400000 and flags 0; without macro, 0x00000000 with UF and NX.
REQ-037 Reset case: assert rst with 2 ops in flight -> out_valid stays 0 and no result emerges for 6 cycles after release.

Source files
------------

// File: rtl/fp_mul_pipe.sv
// Four-stage pipelined IEEE-754 multiplier (unpack, product, normalise, round/pack) with valid/ready flow.
// Define FP_MUL_SUBNORMAL_EN for full subnormal support; otherwise subnormals flush to signed zero.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a_in,
    input  logic [EXP_W+MAN_W:0]   b_in,
    input  logic [2:0]             rm,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [4:0]             flags
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = MAN_W + 1;
    localparam int PW   = 2 * MW;
    localparam int EW   = EXP_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int MAXE = (1 << EXP_W) - 1;
    localparam int SHW  = $clog2(PW + 1);
`ifdef FP_MUL_SUBNORMAL_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef enum logic [1:0] {K_FIN, K_ZERO, K_INF, K_NAN} kind_t;

    typedef struct packed {
        kind_t          kind;
        logic           snan;
        logic [EW-1:0]  exp;
        logic [MW-1:0]  man;
    } op_t;

    typedef struct packed {
        logic sign; kind_t kind; logic nv;
        logic [EW-1:0] exp; logic [MW-1:0] ma; logic [MW-1:0] mb;
        logic [2:0] rm; logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic sign; kind_t kind; logic nv;
        logic [EW-1:0] exp; logic [PW-1:0] prod;
        logic [2:0] rm; logic [TAG_W-1:0] tag;
    } s2_t;

    typedef struct packed {
        logic sign; kind_t kind; logic nv; logic tiny;
        logic [EW-1:0] be; logic [PW-1:0] man; logic sticky;
        logic [2:0] rm; logic [TAG_W-1:0] tag;
    } s3_t;

    function automatic op_t unpack(input logic [W-1:0] x);
        op_t o;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        e = x[W-2:MAN_W];
        f = x[MAN_W-1:0];
        o.kind = K_FIN;
        o.snan = 1'b0;
        o.man  = {1'b1, f};
        o.exp  = $signed({2'b00, e}) - EW'(BIAS);
        if (e == '1) begin
            o.kind = (f == '0) ? K_INF : K_NAN;
            o.snan = (f != '0) && !f[MAN_W-1];
        end else if (e == '0) begin
            if (!SUB_EN || f == '0) begin
                o.kind = K_ZERO;
            end else begin
                o.man = {1'b0, f};
                o.exp = EW'(1 - BIAS);
            end
        end
        return o;
    endfunction

    function automatic logic [SHW-1:0] lzc(input logic [PW-1:0] x);
        logic [SHW-1:0] n;
        n = SHW'(PW);
        for (int i = 0; i < PW; i++) begin
            if (x[i]) n = SHW'(PW - 1 - i);
        end
        return n;
    endfunction

    logic adv;
    logic vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q, vld_p3_d, vld_p3_q, out_vld_d, out_vld_q;
    s1_t st_p1_d, st_p1_q;
    s2_t st_p2_d, st_p2_q;
    s3_t st_p3_d, st_p3_q;
    logic [W-1:0] res_d, res_q, res_p4;
    logic [4:0] flg_d, flg_q, flg_p4;
    logic [TAG_W-1:0] tag_d, tag_q;

    op_t ua, ub;
    logic inf_zero;
    logic [SHW-1:0] lz, sh;
    logic [PW-1:0] mn;
    logic [2*PW-1:0] ext;
    logic signed [EW-1:0] be3, shs, be4;
    logic [MW-1:0] kept;
    logic g, s, inex, inc, ovf, ovf_inf;
    logic [W-2:0] sum;

    // Flow control: the whole pipe freezes while the output is held
    always_comb begin
        adv       = !(out_vld_q && !out_ready);
        in_ready  = adv && !rst;
        vld_p1_d  = adv ? in_valid : vld_p1_q;
        vld_p2_d  = adv ? vld_p1_q : vld_p2_q;
        vld_p3_d  = adv ? vld_p2_q : vld_p3_q;
        out_vld_d = adv ? vld_p3_q : out_vld_q;
        res_d     = adv ? res_p4 : res_q;
        flg_d     = adv ? flg_p4 : flg_q;
        tag_d     = adv ? st_p3_q.tag : tag_q;
    end

    // Stage 1: unpack and classify
    always_comb begin
        ua = unpack(a_in);
        ub = unpack(b_in);
        inf_zero = (ua.kind == K_INF && ub.kind == K_ZERO) || (ua.kind == K_ZERO && ub.kind == K_INF);
        st_p1_d.sign = a_in[W-1] ^ b_in[W-1];
        st_p1_d.nv   = ua.snan | ub.snan | inf_zero;
        if (ua.kind == K_NAN || ub.kind == K_NAN || inf_zero) st_p1_d.kind = K_NAN;
        else if (ua.kind == K_INF || ub.kind == K_INF)       st_p1_d.kind = K_INF;
        else if (ua.kind == K_ZERO || ub.kind == K_ZERO)     st_p1_d.kind = K_ZERO;
        else                                                 st_p1_d.kind = K_FIN;
        st_p1_d.exp = ua.exp + ub.exp;
        st_p1_d.ma  = ua.man;
        st_p1_d.mb  = ub.man;
        st_p1_d.rm  = rm;
        st_p1_d.tag = in_tag;
    end

    // Stage 2: full-width mantissa product
    always_comb begin
        st_p2_d.sign = st_p1_q.sign;
        st_p2_d.kind = st_p1_q.kind;
        st_p2_d.nv   = st_p1_q.nv;
        st_p2_d.exp  = st_p1_q.exp;
        st_p2_d.prod = PW'(st_p1_q.ma) * PW'(st_p1_q.mb);
        st_p2_d.rm   = st_p1_q.rm;
        st_p2_d.tag  = st_p1_q.tag;
    end

    // Stage 3: normalise so the leading one sits at the top; denormalise tiny results
    always_comb begin
        lz  = lzc(st_p2_q.prod);
        mn  = st_p2_q.prod << lz;
        be3 = $signed(st_p2_q.exp) + EW'(BIAS + 1) - EW'(lz);
        shs = EW'(1) - be3;
        sh  = '0;
        ext = '0;
        st_p3_d.sign   = st_p2_q.sign;
        st_p3_d.kind   = (st_p2_q.prod == '0 && st_p2_q.kind == K_FIN) ? K_ZERO : st_p2_q.kind;
        st_p3_d.nv     = st_p2_q.nv;
        st_p3_d.tiny   = (be3 <= 0);
        st_p3_d.be     = be3;
        st_p3_d.man    = mn;
        st_p3_d.sticky = 1'b0;
        st_p3_d.rm     = st_p2_q.rm;
        st_p3_d.tag    = st_p2_q.tag;
        if (SUB_EN && be3 <= 0) begin
            sh  = (shs > PW) ? SHW'(PW) : shs[SHW-1:0];
            ext = {mn, {PW{1'b0}}} >> sh;
            st_p3_d.man    = ext[2*PW-1:PW];
            st_p3_d.sticky = |ext[PW-1:0];
            st_p3_d.be     = '0;
        end
    end

    // Stage 4: round, detect overflow/underflow, pack
    always_comb begin
        be4  = $signed(st_p3_q.be);
        kept = st_p3_q.man[PW-1:PW-MW];
        g    = st_p3_q.man[PW-MW-1];
        s    = (|st_p3_q.man[PW-MW-2:0]) | st_p3_q.sticky;
        inex = g | s;
        case (st_p3_q.rm)
            3'b001:  begin inc = 1'b0;                   ovf_inf = 1'b0;          end
            3'b010:  begin inc = st_p3_q.sign & inex;    ovf_inf = st_p3_q.sign;  end
            3'b011:  begin inc = !st_p3_q.sign & inex;   ovf_inf = !st_p3_q.sign; end
            3'b100:  begin inc = g;                      ovf_inf = 1'b1;          end
            default: begin inc = g & (s | kept[0]);      ovf_inf = 1'b1;          end
        endcase
        sum    = {be4[EXP_W-1:0], kept[MAN_W-1:0]} + {{(W-2){1'b0}}, inc};
        ovf    = 1'b0;
        res_p4 = '0;
        flg_p4 = '0;
        case (st_p3_q.kind)
            K_NAN: begin
                res_p4 = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                flg_p4 = {st_p3_q.nv, 4'b0000};
            end
            K_INF:  res_p4 = {st_p3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            K_ZERO: res_p4 = {st_p3_q.sign, {(W-1){1'b0}}};
            default: begin
                if (!SUB_EN && st_p3_q.tiny) begin
                    res_p4 = {st_p3_q.sign, {(W-1){1'b0}}};
                    flg_p4 = 5'b00011;
                end else begin
                    ovf = (be4 >= MAXE) || (sum[W-2:MAN_W] == '1);
                    if (ovf) begin
                        flg_p4 = 5'b00101;
                        res_p4 = ovf_inf ? {st_p3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                         : {st_p3_q.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                    end else begin
                        res_p4 = {st_p3_q.sign, sum};
                        flg_p4 = {3'b000, SUB_EN & st_p3_q.tiny & inex, inex};
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            vld_p3_q  <= 1'b0;
            out_vld_q <= 1'b0;
            res_q     <= '0;
            flg_q     <= '0;
            tag_q     <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            vld_p3_q  <= vld_p3_d;
            out_vld_q <= out_vld_d;
            res_q     <= res_d;
            flg_q     <= flg_d;
            tag_q     <= tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            st_p1_q <= st_p1_d;
            st_p2_q <= st_p2_d;
            st_p3_q <= st_p3_d;
        end
    end

    assign out_valid = out_vld_q;
    assign result    = res_q;
    assign flags     = flg_q;
    assign out_tag   = tag_q;
endmodule
